// File: rtl/azadi_uart_pkg.sv
// -----------------------------------------------------------------------------
// azadi_uart_pkg
//   Constants and types shared by the UART transmitter and receiver.
//   - tx_state_e : transmitter frame FSM states
//   - DataBits   : data bits per frame (8N1)
//   - StopBits   : stop bits per frame
//   - BitIdxW    : width of the data-bit index counter
// -----------------------------------------------------------------------------
package azadi_uart_pkg;

  localparam int unsigned DataBits = 8;
  localparam int unsigned StopBits = 1;
  localparam int unsigned BitIdxW  = $clog2(DataBits);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

endpackage : azadi_uart_pkg

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
//   Synchronous FIFO buffering bytes for the UART transmitter. Pointers carry
//   one extra MSB so full and empty are distinguished without a spare entry.
//   Read data is presented combinationally for the entry at the read pointer.
// Ports
//   clk_i    in   1          clock, rising edge
//   rst_i    in   1          synchronous reset, active-high; empties the FIFO
//   push_i   in   1          write request (ignored when full)
//   wdata_i  in   Width      write data
//   pop_i    in   1          read request (ignored when empty)
//   rdata_o  out  Width      data at the head of the FIFO
//   full_o   out  1          level == Depth
//   empty_o  out  1          level == 0
//   level_o  out  clog2+1    current occupancy
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
  parameter int unsigned Depth = 8,
  parameter int unsigned Width = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [Width-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [Width-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   level_o
);

  localparam int unsigned AddrW = $clog2(Depth);
  localparam int unsigned PtrW  = AddrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic             push_ok;
  logic             pop_ok;

  assign level_o = wr_ptr_q - rd_ptr_q;
  assign full_o  = (level_o == PtrW'(Depth));
  assign empty_o = (level_o == '0);
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i  & ~empty_o;
  assign rdata_o = mem_q[rd_ptr_q[AddrW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PtrW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage is deliberately left out of reset; the pointers alone define
  // which entries are valid, and a reset-free array maps onto plain RAM/flops.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q[AddrW-1:0]] <= wdata_i;
  end

endmodule : uart_tx_fifo

// File: rtl/iccm_uart_tx.sv
// -----------------------------------------------------------------------------
// iccm_uart_tx
//   UART 8N1 transmitter feeding the ICCM program loader. Bytes are buffered
//   in a small FIFO and serialised LSB-first; each bit lasts max(baud_div,1)
//   clocks. The divisor is captured when a frame starts, so a divisor change
//   only affects the following frame. Frames are sent back to back with no
//   idle gap while the FIFO has data.
// Ports
//   clk_i       in   1          clock, rising edge
//   rst_i       in   1          synchronous reset, active-high (aborts a frame)
//   tx_data_i   in   8          byte to send
//   tx_valid_i  in   1          tx_data_i valid
//   tx_ready_o  out  1          FIFO not full; transfer on valid & ready
//   baud_div_i  in   DivW       clocks per bit; 0 behaves as 1
//   tx_o        out  1          registered serial line, idle high
//   busy_o      out  1          frame in flight or FIFO non-empty
//   fifo_lvl_o  out  clog2+1    FIFO occupancy
// -----------------------------------------------------------------------------
module iccm_uart_tx
  import azadi_uart_pkg::*;
#(
  parameter int unsigned FifoDepth = 8,
  parameter int unsigned DivW      = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [7:0]                   tx_data_i,
  input  logic                         tx_valid_i,
  output logic                         tx_ready_o,
  input  logic [DivW-1:0]              baud_div_i,
  output logic                         tx_o,
  output logic                         busy_o,
  output logic [$clog2(FifoDepth):0]   fifo_lvl_o
);

  // FIFO interface
  logic                fifo_full;
  logic                fifo_empty;
  logic                fifo_pop;
  logic [DataBits-1:0] fifo_rdata;

  // Frame engine state
  tx_state_e           state_q, state_d;
  logic [DataBits-1:0] shift_q, shift_d;
  logic [DivW-1:0]     cnt_q, cnt_d;
  logic [DivW-1:0]     reload_q, reload_d;
  logic [BitIdxW-1:0]  bit_idx_q, bit_idx_d;
  logic                tx_q, tx_d;

  logic [DivW-1:0]     div_eff;
  logic                bit_end;
  logic                start_frame;

  uart_tx_fifo #(
    .Depth (FifoDepth),
    .Width (DataBits)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (tx_valid_i),
    .wdata_i (tx_data_i),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_lvl_o)
  );

  // Ready depends on the registered level only, never on this cycle's pop,
  // so a slot freed by a pop becomes visible one cycle later.
  assign tx_ready_o = ~fifo_full;
  assign busy_o     = (state_q != IDLE) | (fifo_lvl_o != '0);
  assign tx_o       = tx_q;

  assign div_eff = (baud_div_i == '0) ? DivW'(1) : baud_div_i;
  assign bit_end = (cnt_q == '0);

  // tx_d is the line level for the *next* cycle, so every transition below
  // also sets the bit that the new state will drive; tx_o then comes straight
  // from a flop.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    reload_d    = reload_q;
    bit_idx_d   = bit_idx_q;
    tx_d        = tx_q;
    fifo_pop    = 1'b0;
    start_frame = 1'b0;

    if (state_q != IDLE && !bit_end) cnt_d = cnt_q - DivW'(1);

    unique case (state_q)
      IDLE: begin
        tx_d        = 1'b1;
        start_frame = ~fifo_empty;
      end
      START: begin
        if (bit_end) begin
          state_d   = DATA;
          cnt_d     = reload_q;
          bit_idx_d = '0;
          tx_d      = shift_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d = reload_q;
          if (bit_idx_q == BitIdxW'(DataBits - 1)) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + BitIdxW'(1);
            shift_d   = {1'b0, shift_q[DataBits-1:1]};
            tx_d      = shift_q[1];
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          if (!fifo_empty) begin
            start_frame = 1'b1;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase

    // Shared frame launch from IDLE and from the end of a stop bit: pop the
    // head byte and capture the divisor for the whole frame.
    if (start_frame) begin
      fifo_pop = 1'b1;
      state_d  = START;
      shift_d  = fifo_rdata;
      reload_d = div_eff - DivW'(1);
      cnt_d    = div_eff - DivW'(1);
      tx_d     = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      cnt_q     <= '0;
      reload_q  <= '0;
      bit_idx_q <= '0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      reload_q  <= reload_d;
      bit_idx_q <= bit_idx_d;
      tx_q      <= tx_d;
    end
  end

endmodule : iccm_uart_tx

// File: tb/tb_iccm_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_iccm_uart_tx
//   Directed bench for iccm_uart_tx. Inputs change 1 time unit after the
//   rising edge and outputs are sampled at the same point, so each "cycle"
//   below is the interval between two rising edges.
// -----------------------------------------------------------------------------
module tb_iccm_uart_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [15:0] baud_div;
  logic        tx;
  logic        busy;
  logic [3:0]  lvl;

  int n_checks = 0;
  int n_fail   = 0;

  iccm_uart_tx #(
    .FifoDepth (8),
    .DivW      (16)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .tx_data_i  (tx_data),
    .tx_valid_i (tx_valid),
    .tx_ready_o (tx_ready),
    .baud_div_i (baud_div),
    .tx_o       (tx),
    .busy_o     (busy),
    .fifo_lvl_o (lvl)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer a byte, waiting (bounded) for ready; returns one cycle after the
  // transfer with tx_valid dropped.
  task automatic push_byte(input logic [7:0] b);
    int waited;
    waited   = 0;
    tx_data  = b;
    tx_valid = 1'b1;
    while (!tx_ready && waited < 400) begin
      step();
      waited++;
    end
    if (!tx_ready) check("push_timeout", 32'd0, 32'd1);
    step();
    tx_valid = 1'b0;
  endtask

  // Called on the first cycle of a start bit; checks every cycle of the
  // 10-bit frame and returns on the cycle after the stop bit.
  task automatic check_frame(input logic [7:0] b, input int div);
    logic e;
    for (int bi = 0; bi < 10; bi++) begin
      for (int c = 0; c < div; c++) begin
        if (bi == 0)      e = 1'b0;
        else if (bi == 9) e = 1'b1;
        else              e = b[bi-1];
        check($sformatf("frame_%02h_bit%0d_c%0d", b, bi, c), {31'd0, tx}, {31'd0, e});
        check($sformatf("busy_%02h_bit%0d_c%0d", b, bi, c), {31'd0, busy}, 32'd1);
        step();
      end
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_tx"},   {31'd0, tx},   32'd1);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_lvl"},  {28'd0, lvl},  32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    baud_div = 16'd4;
    repeat (3) step();
    check_idle("reset_held");
    check("reset_ready", {31'd0, tx_ready}, 32'd1);
    rst = 1'b0;
    step();
    check_idle("reset_released");

    // 1: div=4, 0xA5, latency N+2 and 40-cycle frame
    baud_div = 16'd4;
    tx_data  = 8'hA5;
    tx_valid = 1'b1;
    check("t1_ready", {31'd0, tx_ready}, 32'd1);
    step();
    tx_valid = 1'b0;
    check("t1_lvl_n1",  {28'd0, lvl},  32'd1);
    check("t1_tx_n1",   {31'd0, tx},   32'd1);
    check("t1_busy_n1", {31'd0, busy}, 32'd1);
    step();
    check_frame(8'hA5, 4);
    check_idle("t1_after");
    step();

    // 2: div=0 behaves as div=1
    baud_div = 16'd0;
    tx_data  = 8'h00;
    tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    check("t2_tx_n1", {31'd0, tx}, 32'd1);
    step();
    check_frame(8'h00, 1);
    check_idle("t2_after");
    step();

    // 3: div=2, nine bytes back to back, FIFO reaches full, no gaps
    baud_div = 16'd2;
    fork
      begin
        for (int i = 1; i <= 9; i++) push_byte(8'(i));
        check("t3_lvl_full",   {28'd0, lvl},      32'd8);
        check("t3_ready_full", {31'd0, tx_ready}, 32'd0);
      end
      begin
        step();
        step();
        for (int i = 1; i <= 9; i++) check_frame(8'(i), 2);
      end
    join
    check_idle("t3_after");
    step();

    // 4: divisor 3 -> 5 mid-frame applies to the next frame only
    baud_div = 16'd3;
    fork
      begin
        push_byte(8'h55);
        push_byte(8'h33);
        repeat (10) step();
        baud_div = 16'd5;
      end
      begin
        step();
        step();
        check_frame(8'h55, 3);
        check_frame(8'h33, 5);
      end
    join
    check_idle("t4_after");
    step();

    // 5: reset during data bit 4 of 0xF0 with a second byte queued
    baud_div = 16'd2;
    push_byte(8'hF0);
    push_byte(8'h77);
    check("t5_start", {31'd0, tx}, 32'd0);
    repeat (11) step();
    check("t5_bit4",      {31'd0, tx},   32'd1);
    check("t5_lvl_before", {28'd0, lvl}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_idle("t5_after_rst");
    check("t5_ready_after_rst", {31'd0, tx_ready}, 32'd1);
    for (int i = 0; i < 12; i++) begin
      check("t5_quiet_tx",   {31'd0, tx},   32'd1);
      check("t5_quiet_busy", {31'd0, busy}, 32'd0);
      step();
    end
    tx_data  = 8'h3C;
    tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    check("t5_tx_n1", {31'd0, tx}, 32'd1);
    step();
    check_frame(8'h3C, 2);
    check_idle("t5_after");
    step();

    // 6: full FIFO, 0xEE held through the pop cycle, accepted one cycle later
    baud_div = 16'd2;
    fork
      begin
        int waited;
        push_byte(8'h11);
        for (int i = 0; i < 8; i++) push_byte(8'(8'h21 + i));
        check("t6_lvl_full",   {28'd0, lvl},      32'd8);
        check("t6_ready_full", {31'd0, tx_ready}, 32'd0);
        tx_data  = 8'hEE;
        tx_valid = 1'b1;
        waited   = 0;
        while (!tx_ready && waited < 100) begin
          check("t6_lvl_while_full", {28'd0, lvl}, 32'd8);
          step();
          waited++;
        end
        check("t6_ready_after_pop", {31'd0, tx_ready}, 32'd1);
        check("t6_lvl_after_pop",   {28'd0, lvl},      32'd7);
        step();
        tx_valid = 1'b0;
        check("t6_lvl_after_accept", {28'd0, lvl}, 32'd8);
      end
      begin
        step();
        step();
        check_frame(8'h11, 2);
        for (int i = 0; i < 8; i++) check_frame(8'(8'h21 + i), 2);
        check_frame(8'hEE, 2);
      end
    join
    check_idle("t6_after");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_iccm_uart_tx
